// File: rtl/ram_sp_init_dp.sv
// ram_sp_init_dp: simple dual-port RAM with write-first bypass and post-reset clear; RAM_PARITY_EN adds per-word even parity
module ram_sp_init_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  init_busy
`ifdef RAM_PARITY_EN
  ,output logic                 parity_error
`endif
);
  localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef RAM_PARITY_EN
  localparam int W = DATA_WIDTH + 1;
`else
  localparam int W = DATA_WIDTH;
`endif
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] wr_word, init_word;
  logic run, rd_go, bypass;
  assign run = state == RUN;
  assign rd_go = run && read_enable;
  assign bypass = write_enable && wr_address == rd_address;
`ifdef RAM_PARITY_EN
  assign wr_word = {^data_in, data_in};
  assign init_word = {^INIT_VALUE, INIT_VALUE};
`else
  assign wr_word = data_in;
  assign init_word = INIT_VALUE;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      if (!run) mem[clr_ptr] <= init_word;
      else if (write_enable) mem[wr_address] <= wr_word;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      init_busy <= 1'b1;
      data_out <= '0;
      rd_valid <= 1'b0;
`ifdef RAM_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        data_out <= bypass ? data_in : mem[rd_address][DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
        parity_error <= !bypass && ^mem[rd_address];
`endif
      end
      if (!run) begin
        clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
        if (clr_ptr == '1) begin
          state <= RUN;
          init_busy <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_ram_sp_init_dp.sv
// tb_ram_sp_init_dp: randomized scoreboard bench for ram_sp_init_dp plus a small 16x16 parameter-sweep instance
module tb_ram_sp_init_dp;
  localparam int DEPTH = 64;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 0, write_enable = 0, read_enable = 0;
  logic [5:0] wr_address = 0, rd_address = 0;
  logic [7:0] data_in = 0, data_out;
  logic rd_valid, init_busy;
  logic s_rst = 0, s_we = 0, s_re = 0;
  logic [3:0] s_wa = 0, s_ra = 0;
  logic [15:0] s_d = 0, s_do;
  logic s_valid, s_busy;
`ifdef RAM_PARITY_EN
  logic parity_error, s_perr;
`endif
  ram_sp_init_dp dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .wr_address(wr_address),
    .data_in(data_in), .read_enable(read_enable), .rd_address(rd_address),
    .data_out(data_out), .rd_valid(rd_valid), .init_busy(init_busy)
`ifdef RAM_PARITY_EN
    , .parity_error(parity_error)
`endif
  );
  ram_sp_init_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .INIT_VALUE(16'hA5A5)) sweep (
    .clk(clk), .rst(s_rst), .write_enable(s_we), .wr_address(s_wa),
    .data_in(s_d), .read_enable(s_re), .rd_address(s_ra),
    .data_out(s_do), .rd_valid(s_valid), .init_busy(s_busy)
`ifdef RAM_PARITY_EN
    , .parity_error(s_perr)
`endif
  );
  int checks = 0, errors = 0;
  logic [7:0] mem_m [DEPTH];
  logic [7:0] exp_q [$];
  int clear_left = 0;
  bit started = 0, sweep_done = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // One clock: apply inputs, then advance the reference model by the rules of that edge.
  task automatic step(input logic r, input logic we, input logic [5:0] wa, input logic [7:0] d,
                      input logic re, input logic [5:0] ra);
    rst = r; write_enable = we; wr_address = wa; data_in = d; read_enable = re; rd_address = ra;
    @(posedge clk);
    if (r) begin
      clear_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = 8'h00;
    end else if (clear_left > 0) clear_left--;
    else begin
      if (re) exp_q.push_back((we && wa == ra) ? d : mem_m[ra]);
      if (we) mem_m[wa] = d;
    end
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic rnd(input int narrow);
    step(0, 1'($urandom_range(0, 1)), narrow ? 6'($urandom_range(0, 7)) : 6'($urandom),
         8'($urandom), 1'($urandom_range(0, 1)), narrow ? 6'($urandom_range(0, 7)) : 6'($urandom));
  endtask
  always @(negedge clk) if (started) begin
    chk("init_busy", 32'(init_busy), 32'(clear_left > 0));
    chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
    if (clear_left > 0) chk("data_out_during_clear", 32'(data_out), 0);
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (rd_valid) chk("data_out", 32'(data_out), 32'(e));
    end
`ifdef RAM_PARITY_EN
    if (rd_valid) chk("parity_error", 32'(parity_error), 0);
`endif
  end
  initial begin
    step(1, 0, 0, 0, 0, 0);
    started = 1;
    for (int i = 0; i < DEPTH; i++)
      if (i == 10) step(0, 1, 3, 8'h99, 1, 3);
      else rnd(0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 31);
    step(0, 0, 0, 0, 1, 63);
    step(0, 0, 0, 0, 1, 3);
    idle();
    step(0, 1, 0, 8'h10, 0, 0);
    step(0, 1, 2, 8'h11, 0, 0);
    step(0, 1, 7, 8'hAF, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 7);
    idle();
    step(0, 1, 5, 8'h55, 0, 0);
    idle();
    step(0, 1, 5, 8'hAF, 1, 5);
    step(0, 1, 9, 8'h22, 1, 7);
    step(0, 0, 0, 0, 1, 9);
    idle();
    for (int i = 0; i < 600; i++) rnd(i % 4 != 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) idle();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) rnd(0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 6'(i));
    idle();
    step(0, 1, 0, 8'h10, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) idle();
    step(0, 0, 0, 0, 1, 0);
    idle();
    idle();
    for (int i = 0; i < 1000 && !sweep_done; i++) @(posedge clk);
    chk("sweep_done", 32'(sweep_done), 1);
    chk("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    s_rst = 1;
    @(posedge clk);
    #1 s_rst = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("s_busy_high", 32'(s_busy), 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("s_busy_low", 32'(s_busy), 0);
    s_re = 1; s_ra = 15;
    @(posedge clk);
    #1 s_re = 0;
    @(negedge clk);
    chk("s_valid_init", 32'(s_valid), 1);
    chk("s_data_init", 32'(s_do), 32'h0000A5A5);
`ifdef RAM_PARITY_EN
    chk("s_parity_init", 32'(s_perr), 0);
`endif
    s_we = 1; s_wa = 15; s_d = 16'h1234;
    @(posedge clk);
    #1 s_we = 0; s_re = 1; s_ra = 15;
    @(posedge clk);
    #1 s_re = 0;
    @(negedge clk);
    chk("s_valid_wr", 32'(s_valid), 1);
    chk("s_data_wr", 32'(s_do), 32'h00001234);
`ifdef RAM_PARITY_EN
    chk("s_parity_wr", 32'(s_perr), 0);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("s_valid_drop", 32'(s_valid), 0);
    sweep_done = 1;
  end
endmodule
